// File: rtl/word_serializer.sv
// Parallel-to-serial converter: one DATA_WIDTH word in, one bit per out_ready cycle out.
// First bit one cycle after accept; words stream back-to-back without a bubble.
module word_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_bit,
  output logic                  out_last
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] sr_q;
  logic [CW-1:0]         cnt_q;
  logic                  rdy_q;
  logic                  head_bit;
  logic                  accept;

  // rdy_q keeps in_ready low while reset is held and rises on the first edge after release.
  assign head_bit  = MSB_FIRST ? sr_q[DATA_WIDTH-1] : sr_q[0];
  assign out_valid = (state_q == SHIFT);
  assign out_bit   = out_valid & head_bit;
  assign out_last  = out_valid & (cnt_q == '0);
  assign in_ready  = (state_q == IDLE) ? rdy_q : (out_last & out_ready);
  assign accept    = in_valid & in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (accept) begin
        state_q <= SHIFT;
        sr_q    <= in_data;
        cnt_q   <= CNT_LOAD;
      end else if ((state_q == SHIFT) && out_ready) begin
        if (cnt_q == '0) begin
          state_q <= IDLE;
        end else begin
          sr_q  <= MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
          cnt_q <= cnt_q - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: scoreboarded 8-bit MSB-first instance plus LSB-first and 1-bit instances.
module tb_word_serializer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_bit, a_out_last;
  logic [7:0] a_in_data;
  logic       b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_bit, b_out_last;
  logic [7:0] b_in_data;
  logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_bit, c_out_last;
  logic [0:0] c_in_data;

  word_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .reset(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_bit(a_out_bit), .out_last(a_out_last));
  word_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .reset(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_bit(b_out_bit), .out_last(b_out_last));
  word_serializer #(.DATA_WIDTH(1), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .reset(b_rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_bit(c_out_bit), .out_last(c_out_last));

  int tests = 0;
  int fails = 0;

  typedef struct { logic b; logic last; } exp_bit_t;
  exp_bit_t sbq[$];

  typedef struct { logic [7:0] word; logic [7:0] exp_seq; logic [15:0] rdy; bit hold; } vec_t;
  vec_t vecs[8];

  logic [15:0] rdy_pat = 16'hFFFF;
  int          rp_idx  = 0;
  logic        a_armed;

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_word(input logic [7:0] w, input logic [7:0] seq, input bit hold);
    a_in_valid = 1'b1;
    a_in_data  = w;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (a_in_ready) begin
        @(posedge clk); #1;
        for (int i = 7; i >= 0; i--) sbq.push_back('{seq[i], (i == 0)});
        if (!hold) begin
          a_in_valid = 1'b0;
          a_in_data  = 8'($urandom);
        end
        return;
      end
      @(posedge clk); #1;
    end
    timeout_fail("a_accept_timeout");
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 500; n++) begin
      @(posedge clk); #1;
      if (sbq.size() == 0) return;
    end
    timeout_fail("a_drain_timeout");
  endtask

  always @(posedge clk or posedge a_rst) begin
    if (a_rst) a_armed <= 1'b0;
    else       a_armed <= 1'b1;
  end

  // Scoreboard monitor: the queue alone predicts valid, bit, last and in_ready.
  always @(negedge clk) begin
    logic ev;
    logic er;
    if (!a_rst && a_armed) begin
      ev = (sbq.size() != 0);
      check("a_out_valid", a_out_valid, ev);
      if (ev) begin
        check("a_out_bit", a_out_bit, sbq[0].b);
        check("a_out_last", a_out_last, sbq[0].last);
        er = sbq[0].last & a_out_ready;
        if (a_out_ready) void'(sbq.pop_front());
      end else begin
        check("a_idle_bit", a_out_bit, 1'b0);
        check("a_idle_last", a_out_last, 1'b0);
        er = 1'b1;
      end
      check("a_in_ready", a_in_ready, er);
    end
  end

  initial begin
    a_out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      a_out_ready = rdy_pat[rp_idx];
      rp_idx = (rp_idx + 1) % 16;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bexp;
    logic [2:0] cbits;

    vecs[0] = '{8'hA5, 8'b1010_0101, 16'hFFFF, 1'b0};
    vecs[1] = '{8'hFF, 8'b1111_1111, 16'hFFFF, 1'b1};
    vecs[2] = '{8'h00, 8'b0000_0000, 16'hFFFF, 1'b0};
    vecs[3] = '{8'hC3, 8'b1100_0011, 16'h5555, 1'b0};
    vecs[4] = '{8'h96, 8'b1001_0110, 16'h1111, 1'b0};
    vecs[5] = '{8'h5A, 8'b0101_1010, 16'hB6DB, 1'b1};
    vecs[6] = '{8'h69, 8'b0110_1001, 16'hB6DB, 1'b1};
    vecs[7] = '{8'h3C, 8'b0011_1100, 16'hB6DB, 1'b0};

    a_rst = 1'b1; b_rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = 8'h00;
    b_in_valid = 1'b0; b_in_data = 8'h00; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_data = 1'b0;  c_out_ready = 1'b1;

    @(posedge clk); @(posedge clk); #1;
    check("rst_a_out_valid", a_out_valid, 1'b0);
    check("rst_a_out_bit",   a_out_bit,   1'b0);
    check("rst_a_out_last",  a_out_last,  1'b0);
    check("rst_a_in_ready",  a_in_ready,  1'b0);
    check("rst_b_in_ready",  b_in_ready,  1'b0);
    check("rst_c_in_ready",  c_in_ready,  1'b0);
    a_rst = 1'b0; b_rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_a_in_ready", a_in_ready, 1'b1);

    for (int i = 0; i < 8; i++) begin
      rdy_pat = vecs[i].rdy;
      send_word(vecs[i].word, vecs[i].exp_seq, vecs[i].hold);
      if (!vecs[i].hold) wait_drain();
    end

    // Reset mid-word: partial 8'hF0 is dropped, 8'h0F follows cleanly.
    rdy_pat = 16'hFFFF;
    @(posedge clk); #1;
    send_word(8'hF0, 8'b1111_0000, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    a_rst = 1'b1;
    #1;
    check("midrst_out_valid", a_out_valid, 1'b0);
    check("midrst_out_bit",   a_out_bit,   1'b0);
    check("midrst_out_last",  a_out_last,  1'b0);
    check("midrst_in_ready",  a_in_ready,  1'b0);
    sbq.delete();
    @(posedge clk); #1;
    a_rst = 1'b0;
    @(posedge clk); #1;
    send_word(8'h0F, 8'b0000_1111, 1'b0);
    wait_drain();

    // LSB-first: 8'h01 leaves as 1 then seven 0s.
    bexp = 8'b0000_0001;
    @(posedge clk); #1;
    b_in_valid = 1'b1; b_in_data = 8'h01;
    @(negedge clk);
    check("b_in_ready_idle", b_in_ready, 1'b1);
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_in_data = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("b_out_valid", b_out_valid, 1'b1);
      check("b_out_bit",   b_out_bit,   bexp[i]);
      check("b_out_last",  b_out_last,  (i == 7));
    end
    @(negedge clk);
    check("b_idle_valid", b_out_valid, 1'b0);

    // One-bit width: 1,0,1 back-to-back, each flagged last.
    cbits = 3'b101;
    @(posedge clk); #1;
    c_in_valid = 1'b1; c_in_data = cbits[0];
    @(negedge clk);
    check("c_in_ready_idle", c_in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i < 2) c_in_data = cbits[i+1];
      else       c_in_valid = 1'b0;
      @(negedge clk);
      check("c_out_valid", c_out_valid, 1'b1);
      check("c_out_last",  c_out_last,  1'b1);
      check("c_out_bit",   c_out_bit,   cbits[i]);
      check("c_in_ready",  c_in_ready,  1'b1);
    end
    @(negedge clk);
    check("c_idle_valid", c_out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
